// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-port data memory controller with a valid/ready request
// channel, a valid/ready response channel and a configurable response latency.
// Decodes RISC-V load/store sizes, checks legality and handles byte lanes.
module dmem_ctrl #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [1:0]  cnt_r, cnt_s;
  logic [31:0] rdata_r, rdata_s;
  logic        err_r;
  logic        accept_s, ok_s, mem_we_s;
  logic [AW-1:0] idx_s;

  // Contents start at zero and are deliberately never touched by reset.
  logic [31:0] mem_r [DEPTH] = '{default: 32'd0};

  // Size/alignment/range legality of a request.
  function automatic logic access_ok(input logic we, input logic [2:0] size,
                                     input logic [31:0] addr);
    logic size_ok, align_ok, range_ok;
    case (size)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = ~we;
      default:                size_ok = 1'b0;
    endcase
    case (size[1:0])
      2'b01:   align_ok = ~addr[0];
      2'b10:   align_ok = (addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    range_ok = (addr[31:2] < 30'(DEPTH));
    return size_ok & align_ok & range_ok;
  endfunction

  // Shift the addressed lane to bit 0 and extend it according to size.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [2:0] size,
                                           input logic [1:0] ofs);
    logic [31:0] sh;
    sh = word >> {ofs, 3'b000};
    case (size)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Merge right-aligned store data into the old word on the selected lanes.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [2:0] size,
                                              input logic [1:0] ofs);
    logic [3:0]  be;
    logic [31:0] data, res;
    case (size[1:0])
      2'b00: begin
        be   = 4'b0001 << ofs;
        data = {4{wdata[7:0]}};
      end
      2'b01: begin
        be   = 4'b0011 << {ofs[1], 1'b0};
        data = {2{wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        data = wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? data[8*i +: 8] : old[8*i +: 8];
    end
    return res;
  endfunction

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = (state_r == RESP);
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;

  assign accept_s = req_valid & (state_r == IDLE);
  assign ok_s     = access_ok(req_we, req_size, req_addr);
  assign idx_s    = req_addr[AW+1:2];
  assign mem_we_s = accept_s & req_we & ok_s;

  // Load result captured at acceptance; stores and errors return zero.
  always_comb begin
    rdata_s = 32'd0;
    if (ok_s && !req_we) begin
      rdata_s = load_ext(mem_r[idx_s], req_size, req_addr[1:0]);
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Next-state and latency counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_s = RESP;
            cnt_s   = 2'd0;
          end else begin
            state_s = WAIT;
            cnt_s   = 2'(LATENCY - 2);
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 2'd0) begin
          state_s = RESP;
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 2'd0;
      end
    endcase
  end

  // State, counter and response registers; response holds until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept_s) begin
        rdata_r <= rdata_s;
        err_r   <= ~ok_s;
      end else if ((state_r == RESP) && rsp_ready) begin
        rdata_r <= 32'd0;
        err_r   <= 1'b0;
      end
    end
  end

  // Store commit on the acceptance edge; reset blocks the write but keeps data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // contents retained across reset
    end else if (mem_we_s) begin
      mem_r[idx_s] <= store_merge(mem_r[idx_s], req_wdata, req_size, req_addr[1:0]);
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with LATENCY=1, one with
// LATENCY=3; expected responses go through a scoreboard queue.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v1, v3;
  logic        req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_ready;
  logic        rdy1, rv1, err1, rdy3, rv3, err3;
  logic [31:0] rd1, rd3;

  int          sel;
  logic        cur_rdy, cur_rv, cur_err;
  logic [31:0] cur_rd;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [32:0] sb [$];

  always #5 clk = ~clk;

  assign cur_rdy = (sel == 3) ? rdy3 : rdy1;
  assign cur_rv  = (sel == 3) ? rv3  : rv1;
  assign cur_err = (sel == 3) ? err3 : err1;
  assign cur_rd  = (sel == 3) ? rd3  : rd1;

  dmem_ctrl #(.DEPTH(64), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv1), .rsp_ready(rsp_ready),
    .rsp_rdata(rd1), .rsp_err(err1)
  );

  dmem_ctrl #(.DEPTH(64), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rv3), .rsp_ready(rsp_ready),
    .rsp_rdata(rd3), .rsp_err(err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: drive, check latency, hold rsp_ready low for
  // 'hold' cycles checking stability, then consume and check return to IDLE.
  task automatic txn(input int which, input logic we, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input int lat, input int hold, input string tag);
    logic [32:0] e;
    int k;
    @(negedge clk);
    sel       = which;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    if (which == 3) v3 = 1'b1; else v1 = 1'b1;
    #1;
    chk({tag, ":req_ready"}, {31'd0, cur_rdy}, 32'd1);
    sb.push_back({exp_err, exp_rd});
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v3 = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (cur_rv === 1'b1) break;
    end
    chk({tag, ":latency"}, 32'(k), 32'(lat));
    e = sb.pop_front();
    chk({tag, ":rdata"}, cur_rd, e[31:0]);
    chk({tag, ":err"}, {31'd0, cur_err}, {31'd0, e[32]});
    repeat (hold) begin
      chk({tag, ":busy_ready"}, {31'd0, cur_rdy}, 32'd0);
      @(negedge clk);
      chk({tag, ":hold_valid"}, {31'd0, cur_rv}, 32'd1);
      chk({tag, ":hold_rdata"}, cur_rd, e[31:0]);
      chk({tag, ":hold_err"}, {31'd0, cur_err}, {31'd0, e[32]});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, ":done_valid"}, {31'd0, cur_rv}, 32'd0);
    chk({tag, ":done_ready"}, {31'd0, cur_rdy}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; v1 = 1'b0; v3 = 1'b0; req_we = 1'b0; req_size = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0; sel = 1;
    repeat (2) @(negedge clk);
    chk("rst1_valid", {31'd0, rv1}, 32'd0);
    chk("rst1_rdata", rd1, 32'd0);
    chk("rst1_err", {31'd0, err1}, 32'd0);
    chk("rst1_ready", {31'd0, rdy1}, 32'd1);
    chk("rst3_valid", {31'd0, rv3}, 32'd0);
    chk("rst3_ready", {31'd0, rdy3}, 32'd1);
    rst_n = 1'b1;

    // word store/load round trip, LATENCY=1
    txn(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1, 0, "sw10");
    txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1, 0, "lw10");
    // byte store, signed/unsigned byte loads
    txn(1, 1'b1, 3'b000, 32'h13, 32'h12345680, 32'h0, 1'b0, 1, 0, "sb13");
    txn(1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 1, 0, "lb13");
    txn(1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, 1, 0, "lbu13");
    txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 1, 0, "lw10b");
    txn(1, 1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFAD, 1'b0, 1, 0, "lb12");
    // illegal: misaligned, bad size; memory untouched
    txn(1, 1'b1, 3'b001, 32'h21, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, "sh21");
    txn(1, 1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1, 1, 0, "lw02");
    txn(1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, "ld011");
    txn(1, 1'b1, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, "st011");
    txn(1, 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, "st100");
    txn(1, 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, "ld110");
    txn(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0, 1, 0, "lw20");
    txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 1, 0, "lw10c");
    // halfword lanes and extension
    txn(1, 1'b1, 3'b001, 32'h22, 32'h1234A5B6, 32'h0, 1'b0, 1, 0, "sh22");
    txn(1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hA5B60000, 1'b0, 1, 0, "lw20b");
    txn(1, 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFA5B6, 1'b0, 1, 0, "lh22");
    txn(1, 1'b0, 3'b101, 32'h22, 32'h0, 32'h0000A5B6, 1'b0, 1, 0, "lhu22");
    txn(1, 1'b0, 3'b001, 32'h20, 32'h0, 32'h0, 1'b0, 1, 0, "lh20");
    // range boundary, no wrap-around
    txn(1, 1'b1, 3'b010, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, "sw100");
    txn(1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 1'b0, 1, 0, "lw00");
    txn(1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, "lw100");
    txn(1, 1'b1, 3'b010, 32'hFC, 32'hCAFEF00D, 32'h0, 1'b0, 1, 0, "swfc");
    txn(1, 1'b0, 3'b010, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0, 1, 0, "lwfc");

    // LATENCY=3 with a stalled consumer
    txn(3, 1'b1, 3'b010, 32'h30, 32'h0BADF00D, 32'h0, 1'b0, 3, 0, "sw30_l3");
    txn(3, 1'b0, 3'b010, 32'h30, 32'h0, 32'h0BADF00D, 1'b0, 3, 5, "lw30_l3");
    txn(3, 1'b0, 3'b100, 32'h31, 32'h0, 32'h000000F0, 1'b0, 3, 2, "lbu31_l3");

    // reset during WAIT discards the response but keeps the store
    @(negedge clk);
    sel = 3; req_we = 1'b1; req_size = 3'b010; req_addr = 32'h4; req_wdata = 32'h12345678;
    v3 = 1'b1;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    @(negedge clk);
    chk("wait_valid", {31'd0, rv3}, 32'd0);
    chk("wait_ready", {31'd0, rdy3}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstwait_valid", {31'd0, rv3}, 32'd0);
    chk("rstwait_ready", {31'd0, rdy3}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    txn(3, 1'b0, 3'b010, 32'h4, 32'h0, 32'h12345678, 1'b0, 3, 0, "lw4_l3");

    // reset held across a would-be acceptance edge: no store, no response
    @(negedge clk);
    sel = 1; rst_n = 1'b0;
    req_we = 1'b1; req_size = 3'b010; req_addr = 32'h8; req_wdata = 32'hFFFFFFFF;
    v1 = 1'b1;
    @(posedge clk);
    #1;
    chk("rstacc_valid", {31'd0, rv1}, 32'd0);
    @(negedge clk);
    v1 = 1'b0;
    rst_n = 1'b1;
    txn(1, 1'b0, 3'b010, 32'h8, 32'h0, 32'h0, 1'b0, 1, 0, "lw08");
    txn(1, 1'b0, 3'b010, 32'hFC, 32'h0, 32'hCAFEF00D, 1'b0, 1, 0, "lwfc_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
